// File: rtl/sram_like_responder_pkg.sv
// Shared types, field widths and helpers for the sram-like responder and the stages that drive it.
package sram_like_responder_pkg;

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2
  } sram_size_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned DCNT_W = 4;

  // Queued entry layout, MSB first: {wr, size, wstrb, idx, wdata}.
  function automatic int unsigned entry_w(input int unsigned addr_w);
    return 1 + SIZE_W + STRB_W + addr_w + DATA_W;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_responder_req_fifo.sv
// In-order request queue: synchronous FIFO with asynchronous active-high reset and exposed count.
module sram_like_responder_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = store[rptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr_q] <= din;
  end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok interface, backed by an internal word memory.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned LATENCY   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         wr,
  input  logic [1:0]                   size,
  input  logic [3:0]                   wstrb,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  output logic                         addr_ok,
  output logic                         data_ok,
  output logic [31:0]                  rdata,
  input  logic                         addr_stall,
  input  logic                         data_stall,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt
);

  localparam int unsigned EW       = entry_w(ADDR_W);
  localparam int unsigned CW       = $clog2(MAX_OUTST) + 1;
  localparam int unsigned IDX_LSB  = DATA_W;
  localparam int unsigned STRB_LSB = IDX_LSB + ADDR_W;
  localparam int unsigned SIZE_LSB = STRB_LSB + STRB_W;
  localparam int unsigned WR_BIT   = SIZE_LSB + SIZE_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [EW-1:0]     push_entry, head;
  logic              push, pop, full, empty;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              head_wr;
  logic [SIZE_W-1:0] head_size;
  logic [STRB_W-1:0] head_strb;
  logic [ADDR_W-1:0] head_idx;
  logic [DATA_W-1:0] head_wdata;
  logic              unused_addr_bits;

  assign push_entry = {wr, size, wstrb, addr[ADDR_W+1:2], wdata};
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign head_wr    = head[WR_BIT];
  assign head_size  = head[SIZE_LSB +: SIZE_W];
  assign head_strb  = head[STRB_LSB +: STRB_W];
  assign head_idx   = head[IDX_LSB +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // No bypass when full: a same-cycle pop does not free a slot for this request.
  assign addr_ok = ~reset & req & ~full & ~addr_stall;
  assign push    = addr_ok;
  assign data_ok = ~reset & ~empty & (dcnt_q == '0) & ~data_stall;
  assign pop     = data_ok;
  assign rdata   = (data_ok && !head_wr) ? mem[head_idx] : '0;

  sram_like_responder_req_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (EW)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outst_cnt)
  );

  // Reload whenever a new entry becomes head; otherwise count down and hold at zero.
  always_comb begin
    dcnt_d = dcnt_q;
    if ((push && empty) || (pop && (outst_cnt > CW'(1) || push))) begin
      dcnt_d = DCNT_W'(LATENCY);
    end else if (dcnt_q != '0) begin
      dcnt_d = dcnt_q - DCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_d;
  end

  always_ff @(posedge clk) begin
    if (pop && head_wr) mem[head_idx] <= merge_bytes(mem[head_idx], head_wdata, head_strb);
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(data_ok && outst_cnt == '0))
        else $error("data_ok raised with an empty queue");
      assert (!(pop && head_wr && head_size == SizeW && head_strb != 4'h0 && head_strb != 4'hf))
        else $error("word-size write with partial byte enables");
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: one responder with LATENCY=0 for most scenarios, one with LATENCY=3 for timing.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, addr_stall, data_stall;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [2:0]  outst_cnt;

  logic        l3_req, l3_wr;
  logic [31:0] l3_addr, l3_wdata;
  logic        l3_addr_ok, l3_data_ok;
  logic [31:0] l3_rdata;
  logic [2:0]  l3_outst_cnt;

  logic        nxt_as, nxt_ds;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  logic [31:0] v3 [4];

  always #5 clk = ~clk;

  sram_like_responder #(
    .ADDR_W (10), .MAX_OUTST (4), .LATENCY (0), .INIT_FILE ("")
  ) dut (
    .clk (clk), .reset (reset), .req (req), .wr (wr), .size (size), .wstrb (wstrb),
    .addr (addr), .wdata (wdata), .addr_ok (addr_ok), .data_ok (data_ok), .rdata (rdata),
    .addr_stall (addr_stall), .data_stall (data_stall), .outst_cnt (outst_cnt)
  );

  sram_like_responder #(
    .ADDR_W (10), .MAX_OUTST (4), .LATENCY (3), .INIT_FILE ("")
  ) dut_l3 (
    .clk (clk), .reset (reset), .req (l3_req), .wr (l3_wr), .size (2'd2), .wstrb (4'hf),
    .addr (l3_addr), .wdata (l3_wdata), .addr_ok (l3_addr_ok), .data_ok (l3_data_ok),
    .rdata (l3_rdata), .addr_stall (1'b0), .data_stall (1'b0), .outst_cnt (l3_outst_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic go(input logic r, input logic w, input logic [1:0] sz, input logic [3:0] st,
                    input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = r; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
    addr_stall = nxt_as; data_stall = nxt_ds;
    #1;
  endtask

  task automatic go3(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    l3_req = r; l3_wr = w; l3_addr = a; l3_wdata = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b1; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
    addr_stall = 0; data_stall = 0; nxt_as = 0; nxt_ds = 0;
    l3_req = 0; l3_wr = 0; l3_addr = 0; l3_wdata = 0;
    for (int k = 0; k < 4; k++) v3[k] = 32'hC0DE_0000 + 32'(k);

    // Reset state, with a request already pending.
    @(negedge clk); #1;
    check("rst_addr_ok", addr_ok, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cnt", 32'(outst_cnt), 0);
    @(negedge clk); reset = 1'b0; req = 1'b0; #1;

    // Preload mem[0x10] and mem[0x20] through the interface.
    go(1, 1, 2'd2, 4'hf, 32'h40, 32'h1234_5678);
    check("pre_addr_ok0", addr_ok, 1);
    go(1, 1, 2'd2, 4'hf, 32'h80, 32'h1111_1111);
    check("pre_data_ok0", data_ok, 1);
    check("pre_wr_rdata", rdata, 0);
    go(0, 0, 0, 0, 0, 0);
    check("pre_data_ok1", data_ok, 1);
    go(0, 0, 0, 0, 0, 0);

    // 1: single read, LATENCY=0.
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    check("t1_addr_ok", addr_ok, 1);
    check("t1_no_data_ok", data_ok, 0);
    go(0, 0, 0, 0, 0, 0);
    check("t1_data_ok", data_ok, 1);
    check("t1_rdata", rdata, 32'h1234_5678);
    check("t1_cnt1", 32'(outst_cnt), 1);
    go(0, 0, 0, 0, 0, 0);
    check("t1_cnt0", 32'(outst_cnt), 0);
    check("t1_idle", data_ok, 0);

    // 3: partial write then read issued the next cycle.
    go(1, 1, 2'd0, 4'b0101, 32'h80, 32'hAABB_CCDD);
    check("t3_wr_accept", addr_ok, 1);
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    check("t3_rd_accept", addr_ok, 1);
    check("t3_wr_resp", data_ok, 1);
    check("t3_wr_rdata", rdata, 0);
    go(0, 0, 0, 0, 0, 0);
    check("t3_rd_resp", data_ok, 1);
    check("t3_merged", rdata, 32'h11BB_11DD);

    // 4: data_stall held with two queued.
    nxt_ds = 1;
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    check("t4_accept2", addr_ok, 1);
    check("t4_stall0", data_ok, 0);
    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 0, 0, 0);
      check($sformatf("t4_stall%0d", i + 1), data_ok, 0);
    end
    check("t4_cnt2", 32'(outst_cnt), 2);
    nxt_ds = 0;
    go(0, 0, 0, 0, 0, 0);
    check("t4_rel_ok0", data_ok, 1);
    check("t4_rel_rd0", rdata, 32'h1234_5678);
    go(0, 0, 0, 0, 0, 0);
    check("t4_rel_ok1", data_ok, 1);
    check("t4_rel_rd1", rdata, 32'h11BB_11DD);
    go(0, 0, 0, 0, 0, 0);
    check("t4_drained", 32'(outst_cnt), 0);

    // 5: push+pop at MAX_OUTST-1, then full with a pop.
    nxt_ds = 1;
    for (int i = 0; i < 3; i++) go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    nxt_ds = 0;
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    check("t5_cnt3", 32'(outst_cnt), 3);
    check("t5_both_ok", addr_ok & data_ok, 1);
    nxt_ds = 1;
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    check("t5_cnt_kept", 32'(outst_cnt), 3);
    nxt_ds = 0;
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    check("t5_full_cnt", 32'(outst_cnt), 4);
    check("t5_full_pop", data_ok, 1);
    check("t5_full_no_bypass", addr_ok, 0);
    go(0, 0, 0, 0, 0, 0);
    check("t5_after_pop", 32'(outst_cnt), 3);
    n = 0;
    while (outst_cnt != 0 && n < 10) begin go(0, 0, 0, 0, 0, 0); n++; end
    check("t5_drain", 32'(outst_cnt), 0);

    // 2: LATENCY=3 instance; preload four words, then four back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      go3(1, 1, 32'(4 * k), v3[k]);
      check($sformatf("t2_pre_ok%0d", k), l3_addr_ok, 1);
    end
    n = 0;
    do begin go3(0, 0, 0, 0); n++; end while (l3_outst_cnt != 0 && n < 40);
    check("t2_pre_drain", 32'(l3_outst_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      go3(1, 0, 32'(4 * k), 0);
      check($sformatf("t2_rd_ok%0d", k), l3_addr_ok, 1);
      check($sformatf("t2_early%0d", k), l3_data_ok, 0);
    end
    go3(1, 0, 32'h10, 0);
    check("t2_full_cnt", 32'(l3_outst_cnt), 4);
    check("t2_fifth_blocked", l3_addr_ok, 0);
    check("t2_first_resp", l3_data_ok, 1);
    check("t2_first_data", l3_rdata, v3[0]);
    for (int k = 1; k < 4; k++) begin
      n = 0;
      do begin go3(0, 0, 0, 0); n++; end while (!l3_data_ok && n < 10);
      check($sformatf("t2_gap%0d", k), 32'(n), 4);
      check($sformatf("t2_data%0d", k), l3_rdata, v3[k]);
    end

    // 6: reset with three queued (unacknowledged write first) and addr_stall toggling.
    nxt_ds = 1;
    go(1, 1, 2'd2, 4'hf, 32'h40, 32'hDEAD_BEEF);
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    nxt_as = 1;
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    check("t6_cnt3", 32'(outst_cnt), 3);
    check("t6_as_block", addr_ok, 0);
    nxt_as = 0;
    go(0, 0, 0, 0, 0, 0);
    nxt_as = 1;
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    @(negedge clk);
    reset = 1'b1; req = 1'b1; nxt_as = 0; nxt_ds = 0; addr_stall = 0; data_stall = 0;
    #1;
    check("t6_rst_cnt", 32'(outst_cnt), 0);
    check("t6_rst_data_ok", data_ok, 0);
    check("t6_rst_addr_ok", addr_ok, 0);
    @(negedge clk); reset = 1'b0; req = 1'b0; #1;
    check("t6_post_cnt", 32'(outst_cnt), 0);
    check("t6_post_data_ok", data_ok, 0);
    go(1, 0, 2'd2, 4'h0, 32'h40, 0);
    go(1, 0, 2'd2, 4'h0, 32'h80, 0);
    check("t6_mem40", rdata, 32'h1234_5678);
    go(0, 0, 0, 0, 0, 0);
    check("t6_mem80", rdata, 32'h11BB_11DD);
    go(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
